byte_frame_packer: RTL and testbench

BYTE_FRAME_PACKER -- requirements
Module: byte_frame_packer

---
 rtl/byte_frame_packer.sv | 201 ++++++++++++++++++++
 tb/tb_byte_frame_packer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_frame_packer.sv
// -----------------------------------------------------------------------------
// byte_frame_packer
//   Collects FRAME_LEN payload bytes from an upstream producer, then emits a
//   frame of FRAME_LEN+2 bytes downstream: a sequence-number header, the
//   buffered payload in arrival order, and a modulo-256 checksum byte.
//   Input and output phases are mutually exclusive (the block is either
//   filling or draining), so in_ready is low for the whole output phase.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   in_data    : payload byte from producer
//   in_valid   : in_data valid
//   in_ready   : block accepts in_data (registered)
//   out_data   : byte to downstream (registered)
//   out_valid  : out_data valid (registered)
//   out_ready  : downstream accepts out_data
//   out_last   : out_data is the frame checksum (registered)
//   frame_cnt  : completed frames, wraps modulo 256
// -----------------------------------------------------------------------------
module byte_frame_packer #(
   parameter int FRAME_LEN = 4,
   parameter int DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [7:0]        frame_cnt
);

   localparam int                IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0]  IDX_ZERO = IDX_W'(0);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [DATA_W-1:0] D_ZERO   = DATA_W'(0);
   localparam logic [DATA_W-1:0] D_ONE    = DATA_W'(1);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_HDR  = 2'd1,
      S_PAY  = 2'd2,
      S_CSUM = 2'd3
   } state_e;

   // Modulo-2^DATA_W checksum accumulation step.
   function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] din);
      return acc + din;
   endfunction

   state_e             state_q,     state_d;
   logic [IDX_W-1:0]   wr_idx_q,    wr_idx_d;
   logic [IDX_W-1:0]   rd_idx_q,    rd_idx_d;
   logic [DATA_W-1:0]  sum_q,       sum_d;
   logic [DATA_W-1:0]  seq_q,       seq_d;
   logic [7:0]         frame_cnt_q, frame_cnt_d;
   logic [DATA_W-1:0]  pay_buf_q [FRAME_LEN];
   logic [DATA_W-1:0]  pay_buf_d [FRAME_LEN];
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q,  out_last_d;
   logic [DATA_W-1:0]  out_data_q,  out_data_d;

   logic               in_xfer_s;
   logic               out_xfer_s;

   // Handshakes are qualified by the registered ready/valid only.
   assign in_xfer_s  = in_valid  & in_ready_q;
   assign out_xfer_s = out_ready & out_valid_q;

   // Next-state, datapath and next-output decode.
   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      sum_d       = sum_q;
      seq_d       = seq_q;
      frame_cnt_d = frame_cnt_q;
      pay_buf_d   = pay_buf_q;

      case (state_q)
         S_FILL: begin
            if (in_xfer_s) begin
               pay_buf_d[wr_idx_q] = in_data;
               sum_d               = csum_add(sum_q, in_data);
               if (wr_idx_q == LAST_IDX) begin
                  wr_idx_d = IDX_ZERO;
                  state_d  = S_HDR;
               end else begin
                  wr_idx_d = wr_idx_q + IDX_ONE;
               end
            end else begin
               state_d = S_FILL;
            end
         end
         S_HDR: begin
            if (out_xfer_s) begin
               rd_idx_d = IDX_ZERO;
               state_d  = S_PAY;
            end else begin
               state_d = S_HDR;
            end
         end
         S_PAY: begin
            if (out_xfer_s) begin
               if (rd_idx_q == LAST_IDX) begin
                  rd_idx_d = IDX_ZERO;
                  state_d  = S_CSUM;
               end else begin
                  rd_idx_d = rd_idx_q + IDX_ONE;
               end
            end else begin
               state_d = S_PAY;
            end
         end
         S_CSUM: begin
            if (out_xfer_s) begin
               state_d     = S_FILL;
               seq_d       = seq_q + D_ONE;
               frame_cnt_d = frame_cnt_q + 8'd1;
               sum_d       = D_ZERO;
            end else begin
               state_d = S_CSUM;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase

      // Outputs are precomputed from the next state so they leave flops directly.
      in_ready_d  = 1'b0;
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      out_data_d  = D_ZERO;
      case (state_d)
         S_FILL: begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
         S_HDR: begin
            out_data_d = seq_d;
         end
         S_PAY: begin
            out_data_d = pay_buf_d[rd_idx_d];
         end
         S_CSUM: begin
            out_data_d = sum_d;
            out_last_d = 1'b1;
         end
         default: begin
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FILL;
         wr_idx_q    <= IDX_ZERO;
         rd_idx_q    <= IDX_ZERO;
         sum_q       <= D_ZERO;
         seq_q       <= D_ZERO;
         frame_cnt_q <= 8'd0;
         for (int i = 0; i < FRAME_LEN; i++) begin
            pay_buf_q[i] <= D_ZERO;
         end
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= D_ZERO;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         sum_q       <= sum_d;
         seq_q       <= seq_d;
         frame_cnt_q <= frame_cnt_d;
         pay_buf_q   <= pay_buf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_byte_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_frame_packer
//   Directed self-checking bench for byte_frame_packer (FRAME_LEN=4).
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_byte_frame_packer;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic [7:0] frame_cnt;

   int   total;
   int   bad;
   logic timeout_seen;

   byte_frame_packer #(.FRAME_LEN(4), .DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .frame_cnt (frame_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something waits forever outside the bounded loops.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Offers four bytes (MSB byte first); in_valid afterwards is set to keep.
   task automatic push_frame(input logic [31:0] bytes, input logic keep);
      int guard;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = bytes[31-8*i -: 8];
         guard    = 0;
         while (in_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 64) timeout_seen = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = keep;
   endtask

   // Samples the next valid output byte with out_ready=1; it transfers on the next rising edge.
   task automatic pull_byte(output logic [7:0] d, output logic l, output logic r);
      int guard;
      @(negedge clk);
      out_ready = 1'b1;
      guard     = 0;
      while (out_valid !== 1'b1 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 64) timeout_seen = 1'b1;
      d = out_data;
      l = out_last;
      r = in_ready;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got rdy=%b vld=%b last=%b want rdy=1 vld=0 last=0",
                  in_ready, out_valid, out_last);
      end
      total++;
      if (out_data !== 8'h00 || frame_cnt !== 8'h00) begin
         bad++;
         $display("FAIL reset_data: got data=%h cnt=%h want 00 00", out_data, frame_cnt);
      end
   endtask

   task automatic test_basic();
      logic [47:0] exp;
      logic [7:0]  d;
      logic        l, r;
      exp = 48'h00_01_02_03_04_0A;
      push_frame(32'h01020304, 1'b0);
      for (int k = 0; k < 6; k++) begin
         pull_byte(d, l, r);
         total++;
         if (d !== exp[47-8*k -: 8] || l !== (k == 5) || r !== 1'b0) begin
            bad++;
            $display("FAIL basic_byte%0d: got data=%h last=%b rdy=%b want data=%h last=%b rdy=0",
                     k, d, l, r, exp[47-8*k -: 8], (k == 5));
         end
      end
      @(negedge clk);
      total++;
      if (frame_cnt !== 8'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_done: got cnt=%h rdy=%b vld=%b want cnt=01 rdy=1 vld=0",
                  frame_cnt, in_ready, out_valid);
      end
   endtask

   task automatic test_checksum_wrap();
      logic [47:0] exp;
      logic [7:0]  d;
      logic        l, r;
      exp = 48'h01_FF_FF_FF_FF_FC;
      push_frame(32'hFFFFFFFF, 1'b0);
      for (int k = 0; k < 6; k++) begin
         pull_byte(d, l, r);
         total++;
         if (d !== exp[47-8*k -: 8] || l !== (k == 5)) begin
            bad++;
            $display("FAIL csum_wrap_byte%0d: got data=%h last=%b want data=%h last=%b",
                     k, d, l, exp[47-8*k -: 8], (k == 5));
         end
      end
      @(negedge clk);
      total++;
      if (frame_cnt !== 8'd2) begin
         bad++;
         $display("FAIL csum_wrap_cnt: got %h want 02", frame_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [39:0] exp;
      logic [7:0]  got [5];
      logic        got_last [5];
      logic [7:0]  d;
      logic        l, r;
      logic [3:0]  pat;
      logic        stall_p;
      logic [7:0]  data_p;
      logic        last_p;
      int          n;
      exp = 40'h10_20_30_40_A0;
      pat = 4'b1001;
      push_frame(32'h10203040, 1'b0);
      pull_byte(d, l, r);
      total++;
      if (d !== 8'h02 || l !== 1'b0) begin
         bad++;
         $display("FAIL bp_header: got data=%h last=%b want 02 0", d, l);
      end
      n       = 0;
      stall_p = 1'b0;
      data_p  = 8'h00;
      last_p  = 1'b0;
      for (int c = 0; c < 30 && n < 5; c++) begin
         @(negedge clk);
         out_ready = (c < 4) ? pat[c] : 1'b1;
         if (stall_p) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== data_p || out_last !== last_p) begin
               bad++;
               $display("FAIL bp_hold_c%0d: got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                        c, out_valid, out_data, out_last, data_p, last_p);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got[n]      = out_data;
            got_last[n] = out_last;
            n++;
         end
         stall_p = (out_valid === 1'b1) && (out_ready === 1'b0);
         data_p  = out_data;
         last_p  = out_last;
      end
      total++;
      if (n !== 5) begin
         bad++;
         $display("FAIL bp_count: got %0d bytes want 5", n);
      end
      for (int k = 0; k < n; k++) begin
         total++;
         if (got[k] !== exp[39-8*k -: 8] || got_last[k] !== (k == 4)) begin
            bad++;
            $display("FAIL bp_byte%0d: got data=%h last=%b want data=%h last=%b",
                     k, got[k], got_last[k], exp[39-8*k -: 8], (k == 4));
         end
      end
   endtask

   task automatic test_continuous_valid();
      logic [47:0] exp_a;
      logic [47:0] exp_b;
      logic [7:0]  d;
      logic        l, r;
      exp_a = 48'h00_11_22_33_44_AA;
      exp_b = 48'h01_05_06_07_08_1A;
      do_reset();
      push_frame(32'h11223344, 1'b1);
      for (int k = 0; k < 6; k++) begin
         pull_byte(d, l, r);
         total++;
         if (d !== exp_a[47-8*k -: 8] || l !== (k == 5) || r !== 1'b0) begin
            bad++;
            $display("FAIL cont_a_byte%0d: got data=%h last=%b rdy=%b want data=%h last=%b rdy=0",
                     k, d, l, r, exp_a[47-8*k -: 8], (k == 5));
         end
      end
      push_frame(32'h05060708, 1'b1);
      for (int k = 0; k < 6; k++) begin
         pull_byte(d, l, r);
         total++;
         if (d !== exp_b[47-8*k -: 8] || l !== (k == 5) || r !== 1'b0) begin
            bad++;
            $display("FAIL cont_b_byte%0d: got data=%h last=%b rdy=%b want data=%h last=%b rdy=0",
                     k, d, l, r, exp_b[47-8*k -: 8], (k == 5));
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (frame_cnt !== 8'd2) begin
         bad++;
         $display("FAIL cont_cnt: got %h want 02", frame_cnt);
      end
   endtask

   task automatic test_seq_wrap();
      logic [47:0] exp;
      logic [7:0]  d;
      logic        l, r;
      do_reset();
      for (int f = 0; f < 256; f++) begin
         push_frame(32'h00000000, 1'b0);
         pull_byte(d, l, r);
         total++;
         if (d !== f[7:0] || frame_cnt !== f[7:0]) begin
            bad++;
            $display("FAIL wrap_hdr%0d: got hdr=%h cnt=%h want %h %h", f, d, frame_cnt, f[7:0], f[7:0]);
         end
         for (int k = 0; k < 5; k++) begin
            pull_byte(d, l, r);
         end
      end
      @(negedge clk);
      total++;
      if (frame_cnt !== 8'h00) begin
         bad++;
         $display("FAIL wrap_cnt: got %h want 00", frame_cnt);
      end
      exp = 48'h00_01_02_03_04_0A;
      push_frame(32'h01020304, 1'b0);
      for (int k = 0; k < 6; k++) begin
         pull_byte(d, l, r);
         total++;
         if (d !== exp[47-8*k -: 8] || l !== (k == 5)) begin
            bad++;
            $display("FAIL wrap_f257_byte%0d: got data=%h last=%b want data=%h last=%b",
                     k, d, l, exp[47-8*k -: 8], (k == 5));
         end
      end
   endtask

   task automatic test_reset_mid_pay();
      logic [47:0] exp;
      logic [7:0]  d;
      logic        l, r;
      push_frame(32'h01020304, 1'b0);
      pull_byte(d, l, r);
      pull_byte(d, l, r);
      pull_byte(d, l, r);
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h03) begin
         bad++;
         $display("FAIL midpay_pre: got vld=%b data=%h want vld=1 data=03", out_valid, out_data);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || frame_cnt !== 8'h00) begin
         bad++;
         $display("FAIL midpay_post: got vld=%b rdy=%b last=%b cnt=%h want 0 1 0 00",
                  out_valid, in_ready, out_last, frame_cnt);
      end
      exp = 48'h00_09_08_07_06_1E;
      push_frame(32'h09080706, 1'b0);
      for (int k = 0; k < 6; k++) begin
         pull_byte(d, l, r);
         total++;
         if (d !== exp[47-8*k -: 8] || l !== (k == 5)) begin
            bad++;
            $display("FAIL midpay_next_byte%0d: got data=%h last=%b want data=%h last=%b",
                     k, d, l, exp[47-8*k -: 8], (k == 5));
         end
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      timeout_seen = 1'b0;
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_data      = 8'h00;
      out_ready    = 1'b0;

      test_reset();
      test_basic();
      test_checksum_wrap();
      test_backpressure();
      test_continuous_valid();
      test_seq_wrap();
      test_reset_mid_pay();

      total++;
      if (timeout_seen !== 1'b0) begin
         bad++;
         $display("FAIL handshake_timeout: got timeout=%b want 0", timeout_seen);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
